// File: rtl/lut_neuron_array.sv
// rtl/lut_neuron_array.sv - runtime-programmable truth-table neuron array
// Per-neuron LUTs loaded over a config port; streaming lookup with a registered output.
module lut_neuron_array #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 1,
  parameter int NUM_NEURONS = 4,
  parameter int NW          = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [NW-1:0]                   cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  input  logic                            cfg_commit,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  output logic                            busy
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [NW:0] NUM_N = (NW+1)'(NUM_NEURONS);

  typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [OUT_BITS-1:0]             mem [NUM_NEURONS][DEPTH];
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;
  logic                            wr_en;
  logic                            accept;

  // Writes to a neuron index beyond the array are handshaken but dropped.
  assign wr_en  = (state == S_CFG) && cfg_valid && ({1'b0, cfg_neuron} < NUM_N);
  assign accept = in_valid && in_ready;

  // Table storage is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cfg_neuron][cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      lookup[n*OUT_BITS +: OUT_BITS] = mem[n][in_data[n*IN_BITS +: IN_BITS]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CFG;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_CFG: begin
        cfg_ready = 1'b1;
        if (cfg_commit) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        in_ready = !out_valid || out_ready;
        // The config request stays pending; it is served once the pipeline is empty.
        if (cfg_valid) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!out_valid || out_ready) begin
          state_nxt = S_CFG;
        end
      end
      default: state_nxt = S_CFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_array.sv
// tb/tb_lut_neuron_array.sv - directed bench for lut_neuron_array
module tb_lut_neuron_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_commit;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [0:0]  cfg_data;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [23:0] in_data;
  logic [3:0]  out_data;

  logic        cfg_valid_3, cfg_ready_3, cfg_commit_3;
  logic [1:0]  cfg_neuron_3;
  logic [5:0]  cfg_addr_3;
  logic [0:0]  cfg_data_3;
  logic        in_valid_3, in_ready_3, out_valid_3, out_ready_3, busy_3;
  logic [17:0] in_data_3;
  logic [2:0]  out_data_3;

  lut_neuron_array dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_neuron(cfg_neuron),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  lut_neuron_array #(.NUM_NEURONS(3)) dut3 (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid_3), .cfg_ready(cfg_ready_3), .cfg_neuron(cfg_neuron_3),
    .cfg_addr(cfg_addr_3), .cfg_data(cfg_data_3), .cfg_commit(cfg_commit_3),
    .in_valid(in_valid_3), .in_ready(in_ready_3), .in_data(in_data_3),
    .out_valid(out_valid_3), .out_ready(out_ready_3), .out_data(out_data_3),
    .busy(busy_3)
  );

  typedef struct {
    logic [23:0] din;
    logic [3:0]  exp;
  } vec_t;

  vec_t tbl[4];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int n, input int a, input logic d, input logic commit);
    cfg_valid  = 1'b1;
    cfg_neuron = n[1:0];
    cfg_addr   = a[5:0];
    cfg_data   = d;
    cfg_commit = commit;
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic wr3(input int n, input int a, input logic d);
    cfg_valid_3  = 1'b1;
    cfg_neuron_3 = n[1:0];
    cfg_addr_3   = a[5:0];
    cfg_data_3   = d;
    tick();
    cfg_valid_3  = 1'b0;
  endtask

  initial begin
    // slices {n3,n2,n1,n0}; n0 = 1 except addr 42, n1..n3 = parity
    tbl[0] = '{{6'd7,  6'd3,  6'd1,  6'd42}, 4'b1010};
    tbl[1] = '{{6'd63, 6'd63, 6'd0,  6'd43}, 4'b0001};
    tbl[2] = '{{6'd32, 6'd22, 6'd21, 6'd0},  4'b1111};
    tbl[3] = '{{6'd8,  6'd12, 6'd62, 6'd63}, 4'b1011};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    cfg_valid_3 = 1'b0; cfg_commit_3 = 1'b0; cfg_neuron_3 = '0; cfg_addr_3 = '0;
    cfg_data_3 = '0; in_valid_3 = 1'b0; in_data_3 = '0; out_ready_3 = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);

    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = tbl[0].din;
    #1 chk("cfg_in_ready", in_ready, 0);
    tick();
    chk("cfg_no_accept", out_valid, 0);
    in_valid = 1'b0;

    // (3,63) is preloaded with 1 so the final write+commit must visibly overwrite it
    wr(3, 63, 1'b1, 1'b0);
    for (int a = 0; a < 64; a++) wr(0, a, (a != 42), 1'b0);
    for (int n = 1; n < 4; n++)
      for (int a = 0; a < 64; a++)
        if (!(n == 3 && a == 63)) wr(n, a, ^a[5:0], 1'b0);
    wr(3, 63, 1'b0, 1'b1);

    chk("run_first_in_ready", in_ready, 1);
    chk("run_cfg_ready", cfg_ready, 0);
    chk("run_busy", busy, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = tbl[i].din;
      #1 chk($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      tick();
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_data_%0d", i), out_data, tbl[i].exp);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle", out_valid, 0);

    // backpressure: five cycles of out_ready=0, only the first vector gets in
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = tbl[0].din;
    #1 chk("bp_first_accept", in_ready, 1);
    tick();
    in_data = tbl[1].din;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      chk($sformatf("bp_valid_%0d", k), out_valid, 1);
      chk($sformatf("bp_hold_%0d", k), out_data, tbl[0].exp);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      in_data = tbl[i].din;
      #1;
      chk($sformatf("rel_in_ready_%0d", i), in_ready, 1);
      chk($sformatf("rel_prev_%0d", i), out_data, tbl[i-1].exp);
      tick();
      chk($sformatf("rel_data_%0d", i), out_data, tbl[i].exp);
    end
    in_valid = 1'b0;
    tick();
    chk("rel_no_dup", out_valid, 0);

    // reconfigure while an output is stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = tbl[0].din;
    tick();
    in_valid   = 1'b0;
    cfg_valid  = 1'b1;
    cfg_neuron = 2'd0;
    cfg_addr   = 6'd42;
    cfg_data   = 1'b1;
    #1 chk("rc_run_cfg_ready", cfg_ready, 0);
    tick();
    chk("rc_busy0", busy, 1);
    chk("rc_cfg_ready0", cfg_ready, 0);
    chk("rc_in_ready0", in_ready, 0);
    tick();
    chk("rc_busy1", busy, 1);
    chk("rc_hold", out_data, tbl[0].exp);
    chk("rc_valid_hold", out_valid, 1);
    out_ready = 1'b1;
    #1 chk("rc_busy2", busy, 1);
    tick();
    chk("rc_cfg_busy", busy, 0);
    chk("rc_cfg_ready", cfg_ready, 1);
    chk("rc_drained", out_valid, 0);
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    in_valid = 1'b1;
    in_data  = tbl[0].din;
    tick();
    chk("rc_new_value", out_data, 4'b1011);
    in_valid = 1'b0;

    // reset with an output pending
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = tbl[2].din;
    tick();
    chk("mr_pending", out_valid, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_cfg_ready", cfg_ready, 1);
    chk("mr_busy", busy, 0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = tbl[1].din;
    tick();
    chk("mr_retained_1", out_data, tbl[1].exp);
    in_data = tbl[0].din;
    tick();
    chk("mr_retained_0", out_data, 4'b1011);
    in_valid = 1'b0;

    // three-neuron instance: writes to neuron 3 are accepted and dropped
    wr3(0, 0, 1'b1); wr3(1, 0, 1'b0); wr3(2, 0, 1'b1);
    wr3(0, 1, 1'b1); wr3(1, 1, 1'b0); wr3(2, 1, 1'b1);
    cfg_valid_3  = 1'b1;
    cfg_neuron_3 = 2'd3;
    cfg_addr_3   = 6'd0;
    cfg_data_3   = 1'b0;
    #1 chk("oor_accept", cfg_ready_3, 1);
    tick();
    wr3(3, 1, 1'b1);
    cfg_commit_3 = 1'b1;
    tick();
    cfg_commit_3 = 1'b0;
    out_ready_3 = 1'b1;
    in_valid_3  = 1'b1;
    in_data_3   = '0;
    tick();
    chk("oor_addr0", out_data_3, 3'b101);
    in_data_3 = {6'd1, 6'd1, 6'd1};
    tick();
    chk("oor_addr1", out_data_3, 3'b101);
    in_valid_3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
